// File: rtl/lcd_pixel_src.sv
// lcd_pixel_src: framebuffer / test-pattern pixel source aligned to LCD timing
// Ports:
//   clk, rst                      pixel clock, synchronous active-high reset
//   de_in, hsync_in, vsync_in     timing from the generator
//   h_cnt, v_cnt                  1-based active coordinates (0 outside DE)
//   mode_sel, fg_color            0 fb, 1 colour bars, 2 grid, 3 solid fg_color
//   mem_rd, mem_addr, mem_rdata   framebuffer read port, data MEM_LAT clocks after mem_rd
//   lcd_de, lcd_hsync, lcd_vsync  panel timing, delayed MEM_LAT+2 clocks
//   lcd_rgb                       RGB565 aligned with lcd_de, 0 in blanking
//   frame_cnt                     frames started since reset
// Build option: LCD_PIXEL_SRC_SCALE2_EN selects a half-resolution framebuffer shown as 2x2 blocks.
module lcd_pixel_src #(
    parameter int PIXEL_WIDTH  = 480,
    parameter int PIXEL_HEIGHT = 272,
    parameter int MEM_LAT      = 2,
    parameter int ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [1:0]        mode_sel,
    input  logic [15:0]       fg_color,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              lcd_de,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic [15:0]       lcd_rgb,
    output logic [7:0]        frame_cnt
);
    localparam int LAT = MEM_LAT + 2;
    localparam int BAR = PIXEL_WIDTH / 8;
`ifdef LCD_PIXEL_SRC_SCALE2_EN
    localparam int LINE_STEP = PIXEL_WIDTH / 2;
`else
    localparam int LINE_STEP = PIXEL_WIDTH;
`endif
    // index 8 is the black tail used for remainder pixels
    localparam logic [8:0][15:0] BARS = {16'h0000, 16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                         16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

    typedef enum logic {WAIT_SYNC, RUN} state_t;
    state_t state, state_nx;

    logic                      vs_prev, de_prev;
    logic [1:0]                mode;
    logic [ADDR_W-1:0]         line_base, addr_off;
    logic [9:0]                bar_pc, cur_pc, hm1;
    logic [3:0]                bar_idx, cur_idx, vm1;
    logic [LAT-1:0]            hs_sr, vs_sr;
    logic [MEM_LAT:0]          de_sr, fb_sr;
    logic [MEM_LAT:0][15:0]    pat_sr;
    logic                      vs_rise, de_rise, de_fall, de_eff, fb_mode, bar_end, line_step;
    logic [15:0]               grid, pat;
    logic                      unused_ok;

    assign vs_rise   = vsync_in & ~vs_prev;
    assign de_rise   = de_in & ~de_prev;
    assign de_fall   = ~de_in & de_prev;
    assign de_eff    = de_in && state == RUN;
    assign fb_mode   = mode == 2'd0;
    assign hm1       = h_cnt - 10'd1;
    assign vm1       = v_cnt[3:0] - 4'd1;
    assign cur_pc    = de_rise ? 10'd0 : bar_pc;
    assign cur_idx   = de_rise ? 4'd0 : bar_idx;
    assign bar_end   = cur_pc == 10'(BAR - 1);
    assign grid      = (hm1[3:0] == 4'd0 || vm1 == 4'd0) ? 16'hFFFF : 16'h0000;
    assign pat       = mode == 2'd1 ? BARS[cur_idx] : mode == 2'd2 ? grid : fg_color;
    assign lcd_hsync = hs_sr[LAT-1];
    assign lcd_vsync = vs_sr[LAT-1];
    // upper line-count bits and the frame height never reach the datapath
    assign unused_ok = ^{v_cnt[9:4], PIXEL_HEIGHT[0]};

`ifdef LCD_PIXEL_SRC_SCALE2_EN
    logic v_odd;
    assign addr_off  = ADDR_W'(hm1 >> 1);
    assign line_step = de_fall && !v_odd;
`else
    assign addr_off  = ADDR_W'(hm1);
    assign line_step = de_fall;
`endif

    always_comb begin
        state_nx = (state == WAIT_SYNC && vs_rise) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_SYNC;
            vs_prev   <= 1'b0;
            de_prev   <= 1'b0;
            mode      <= 2'd0;
            line_base <= '0;
            frame_cnt <= 8'd0;
            bar_pc    <= 10'd0;
            bar_idx   <= 4'd0;
            hs_sr     <= '0;
            vs_sr     <= '0;
            de_sr     <= '0;
            fb_sr     <= '0;
            pat_sr    <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            lcd_de    <= 1'b0;
            lcd_rgb   <= 16'h0000;
`ifdef LCD_PIXEL_SRC_SCALE2_EN
            v_odd     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            vs_prev <= vsync_in;
            de_prev <= de_in;
            hs_sr   <= {hs_sr[LAT-2:0], hsync_in};
            vs_sr   <= {vs_sr[LAT-2:0], vsync_in};
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 8'd1;
                mode      <= mode_sel;
                line_base <= '0;
            end else if (line_step) begin
                line_base <= line_base + ADDR_W'(LINE_STEP);
            end
`ifdef LCD_PIXEL_SRC_SCALE2_EN
            if (de_in) v_odd <= v_cnt[0];
`endif
            // bar counter restarts on every line; index saturates on the black tail
            if (de_in) begin
                bar_pc  <= bar_end ? 10'd0 : cur_pc + 10'd1;
                bar_idx <= (bar_end && cur_idx != 4'd8) ? cur_idx + 4'd1 : cur_idx;
            end
            mem_rd <= de_eff && fb_mode;
            if (de_eff && fb_mode) mem_addr <= line_base + addr_off;
            // pattern and mode flag travel alongside the RAM latency
            de_sr   <= {de_sr[MEM_LAT-1:0], de_eff};
            fb_sr   <= {fb_sr[MEM_LAT-1:0], fb_mode};
            pat_sr  <= {pat_sr[MEM_LAT-1:0], pat};
            lcd_de  <= de_sr[MEM_LAT];
            lcd_rgb <= !de_sr[MEM_LAT] ? 16'h0000 : fb_sr[MEM_LAT] ? mem_rdata : pat_sr[MEM_LAT];
        end
    end
endmodule

// File: tb/tb_lcd_pixel_src.sv
// tb_lcd_pixel_src: directed bench for lcd_pixel_src with a 480x4 frame
module tb_lcd_pixel_src;
    localparam int W  = 480;
    localparam int H  = 4;
    localparam int AW = 17;

    logic          clk = 1'b0, rst = 1'b1;
    logic          de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [9:0]    h_cnt = 10'd0, v_cnt = 10'd0;
    logic [1:0]    mode_sel = 2'd0;
    logic [15:0]   fg_color = 16'h0000;
    logic          mem_rd, lcd_de, lcd_hsync, lcd_vsync;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata, lcd_rgb, r1, r2;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    lcd_pixel_src #(.PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .MEM_LAT(2), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .mode_sel(mode_sel), .fg_color(fg_color),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
        .lcd_rgb(lcd_rgb), .frame_cnt(frame_cnt)
    );

    // two-clock RAM whose contents equal the low address bits
    always @(posedge clk) begin
        r1 <= mem_addr[15:0];
        r2 <= r1;
    end
    assign mem_rdata = r2;

    int total = 0, bad = 0;

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    logic [3:0]    hs_h = 4'd0, vs_h = 4'd0;
    int            ncyc = 0, t_in = -1, t_out = -1;
    bit            arm = 1'b0;
    int            de_cnt = 0, rd_cnt = 0, blank_nz = 0;
    int            lline = 0, lpx = 0, aline = 0, apx = 0;
    logic          lde_p = 1'b0, lvs_p = 1'b0, rd_p = 1'b0;
    logic [15:0]   cap [1:H][1:W];
    logic [AW-1:0] acap [1:H][1:W];

    // input history as sampled by the DUT; hs_h[3] is the value from four cycles back
    always @(posedge clk) begin
        hs_h = rst ? 4'd0 : {hs_h[2:0], hsync_in};
        vs_h = rst ? 4'd0 : {vs_h[2:0], vsync_in};
        if (arm && t_in < 0 && de_in) t_in = ncyc;
    end

    always @(negedge clk) begin
        ncyc++;
        check("hsync_dly4", int'(lcd_hsync), int'(hs_h[3]));
        check("vsync_dly4", int'(lcd_vsync), int'(vs_h[3]));
        if (lcd_vsync && !lvs_p) begin
            lline = 0;
            aline = 0;
        end
        if (lcd_de && !lde_p) begin
            lline++;
            lpx = 0;
        end
        if (lcd_de) begin
            lpx++;
            de_cnt++;
            if (arm && t_out < 0) t_out = ncyc;
            if (lline >= 1 && lline <= H && lpx <= W) cap[lline][lpx] = lcd_rgb;
        end else if (lcd_rgb != 16'h0000) begin
            blank_nz++;
        end
        if (mem_rd && !rd_p) begin
            aline++;
            apx = 0;
        end
        if (mem_rd) begin
            apx++;
            rd_cnt++;
            if (aline >= 1 && aline <= H && apx <= W) acap[aline][apx] = mem_addr;
        end
        lde_p = lcd_de;
        lvs_p = lcd_vsync;
        rd_p  = mem_rd;
    end

    task automatic idle(input int n);
        de_in = 1'b0;
        h_cnt = 10'd0;
        v_cnt = 10'd0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_line(input int v);
        hsync_in = 1'b1;
        idle(2);
        hsync_in = 1'b0;
        idle(4);
        for (int h = 1; h <= W; h++) begin
            de_in = 1'b1;
            h_cnt = 10'(h);
            v_cnt = 10'(v);
            @(negedge clk);
        end
        idle(4);
    endtask

    // switch_at: after this line mode_sel is moved to solid, which must not take effect mid-frame
    task automatic do_frame(input int switch_at);
        foreach (cap[i, j]) cap[i][j] = 16'hDEAD;
        foreach (acap[i, j]) acap[i][j] = AW'(17'h1DEAD);
        de_cnt = 0;
        rd_cnt = 0;
        blank_nz = 0;
        vsync_in = 1'b1;
        idle(3);
        vsync_in = 1'b0;
        idle(5);
        for (int v = 1; v <= H; v++) begin
            do_line(v);
            if (v == switch_at) mode_sel = 2'd3;
        end
        idle(6);
    endtask

    typedef struct { int fr; bit adr; int ln; int px; int want; } vec_t;
    vec_t vt [$];

    function automatic vec_t mk(input int fr, input int adr, input int ln, input int px, input int want);
        vec_t v;
        v.fr = fr;
        v.adr = (adr != 0);
        v.ln = ln;
        v.px = px;
        v.want = want;
        return v;
    endfunction

    task automatic run_table(input int f);
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].fr == f)
                check($sformatf("f%0d_%s_l%0d_p%0d", f, vt[i].adr ? "addr" : "rgb", vt[i].ln, vt[i].px),
                      vt[i].adr ? int'(acap[vt[i].ln][vt[i].px]) : int'(cap[vt[i].ln][vt[i].px]),
                      vt[i].want);
        end
    endtask

    initial begin
`ifdef LCD_PIXEL_SRC_SCALE2_EN
        vt.push_back(mk(0, 0, 1, 1, 'h0000));
        vt.push_back(mk(0, 0, 1, 480, 'h00EF));
        vt.push_back(mk(0, 0, 2, 1, 'h0000));
        vt.push_back(mk(0, 0, 2, 480, 'h00EF));
        vt.push_back(mk(0, 0, 3, 1, 'h00F0));
        vt.push_back(mk(0, 0, 4, 480, 'h01DF));
        vt.push_back(mk(0, 1, 1, 2, 0));
        vt.push_back(mk(0, 1, 1, 3, 1));
        vt.push_back(mk(0, 1, 2, 480, 239));
        vt.push_back(mk(0, 1, 3, 1, 240));
        vt.push_back(mk(0, 1, 4, 480, 479));
`else
        vt.push_back(mk(0, 0, 1, 1, 'h0000));
        vt.push_back(mk(0, 0, 1, 480, 'h01DF));
        vt.push_back(mk(0, 0, 2, 1, 'h01E0));
        vt.push_back(mk(0, 0, 3, 2, 'h03C1));
        vt.push_back(mk(0, 0, 4, 480, 'h077F));
        vt.push_back(mk(0, 1, 1, 1, 0));
        vt.push_back(mk(0, 1, 2, 1, 480));
        vt.push_back(mk(0, 1, 4, 480, 1919));
`endif
        vt.push_back(mk(1, 0, 1, 1, 'hFFFF));
        vt.push_back(mk(1, 0, 1, 60, 'hFFFF));
        vt.push_back(mk(1, 0, 1, 61, 'hFFE0));
        vt.push_back(mk(1, 0, 1, 120, 'hFFE0));
        vt.push_back(mk(1, 0, 1, 121, 'h07FF));
        vt.push_back(mk(1, 0, 1, 181, 'h07E0));
        vt.push_back(mk(1, 0, 2, 300, 'hF81F));
        vt.push_back(mk(1, 0, 3, 360, 'hF800));
        vt.push_back(mk(1, 0, 3, 420, 'h001F));
        vt.push_back(mk(1, 0, 4, 421, 'h0000));
        vt.push_back(mk(1, 0, 4, 480, 'h0000));
        vt.push_back(mk(2, 0, 1, 1, 'hFFFF));
        vt.push_back(mk(2, 0, 1, 250, 'hFFFF));
        vt.push_back(mk(2, 0, 2, 1, 'hFFFF));
        vt.push_back(mk(2, 0, 2, 2, 'h0000));
        vt.push_back(mk(2, 0, 2, 16, 'h0000));
        vt.push_back(mk(2, 0, 2, 17, 'hFFFF));
        vt.push_back(mk(2, 0, 3, 33, 'hFFFF));
        vt.push_back(mk(2, 0, 3, 34, 'h0000));
        vt.push_back(mk(2, 0, 4, 97, 'hFFFF));
        vt.push_back(mk(2, 0, 4, 100, 'h0000));
        vt.push_back(mk(3, 0, 1, 1, 'hF800));
        vt.push_back(mk(3, 0, 2, 240, 'hF800));
        vt.push_back(mk(3, 0, 4, 480, 'hF800));

        @(negedge clk);
        check("rst_lcd_de", int'(lcd_de), 0);
        check("rst_lcd_rgb", int'(lcd_rgb), 0);
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);

        // reset held 5 cycles and released while lines are running, no vsync yet
        de_cnt = 0;
        rd_cnt = 0;
        fork
            begin
                do_line(2);
                do_line(3);
            end
            begin
                repeat (4) @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(6);
        check("wait_lcd_de_cnt", de_cnt, 0);
        check("wait_mem_rd_cnt", rd_cnt, 0);
        check("wait_frame_cnt", int'(frame_cnt), 0);

        mode_sel = 2'd0;
        arm = 1'b1;
        do_frame(0);
        arm = 1'b0;
        check("fb_frame_cnt", int'(frame_cnt), 1);
        check("fb_latency", t_out - t_in, 4);
        check("fb_de_cnt", de_cnt, H * W);
        check("fb_rd_cnt", rd_cnt, H * W);
        check("fb_blank", blank_nz, 0);
        run_table(0);

        mode_sel = 2'd1;
        do_frame(0);
        check("bars_frame_cnt", int'(frame_cnt), 2);
        check("bars_rd_cnt", rd_cnt, 0);
        check("bars_de_cnt", de_cnt, H * W);
        check("bars_blank", blank_nz, 0);
        run_table(1);

        mode_sel = 2'd2;
        fg_color = 16'hF800;
        do_frame(2);
        check("grid_frame_cnt", int'(frame_cnt), 3);
        check("grid_blank", blank_nz, 0);
        run_table(2);

        do_frame(0);
        check("solid_frame_cnt", int'(frame_cnt), 4);
        check("solid_de_cnt", de_cnt, H * W);
        run_table(3);

        repeat (256) begin
            vsync_in = 1'b1;
            idle(1);
            vsync_in = 1'b0;
            idle(2);
        end
        idle(6);
        check("wrap_frame_cnt", int'(frame_cnt), 4);

        // reset coinciding with a vsync edge must not count the frame
        vsync_in = 1'b1;
        rst = 1'b1;
        idle(1);
        vsync_in = 1'b0;
        rst = 1'b0;
        idle(3);
        check("rst_vs_frame_cnt", int'(frame_cnt), 0);
        de_cnt = 0;
        rd_cnt = 0;
        do_line(1);
        idle(6);
        check("rst_vs_de_cnt", de_cnt, 0);
        check("rst_vs_rd_cnt", rd_cnt, 0);
        vsync_in = 1'b1;
        idle(1);
        vsync_in = 1'b0;
        idle(2);
        check("resync_frame_cnt", int'(frame_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
